mul_rr_sched: RTL and testbench

Round-robin scheduler that shares one pipelined 8x8 unsigned multiplier (`multi_pipe_8bit` interface, fixed latency) between N requesters. It accepts operand pairs over per-channel valid/ready handshakes and issues at most one operation per cycle. It tags each in-flight operation with its channel and steers the returning 16-bit product into that channel's response register. It sits between the requesting datapath blocks and the multiplier instance.

---
 rtl/mul_rr_sched.sv | 132 +++++++++++++
 tb/tb_mul_rr_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_sched.sv
// Round-robin scheduler that shares one pipelined 8x8 multiplier among N requesters.
// Each issued operation carries a channel tag so the product returns to that channel.
module mul_rr_sched #(
  parameter int N   = 4,
  parameter int LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [8*N-1:0]  req_a,
  input  logic [8*N-1:0]  req_b,
  output logic [N-1:0]    rsp_valid,
  input  logic [N-1:0]    rsp_ready,
  output logic [16*N-1:0] rsp_data,
  output logic            mul_en_in,
  output logic [7:0]      mul_a,
  output logic [7:0]      mul_b,
  input  logic            mul_en_out,
  input  logic [15:0]     mul_out,
  output logic            err
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int NS = LAT + 1;
  localparam logic [IW-1:0] PTR_RST = IW'(N - 1);

  logic [N-1:0]          busy_q, busy_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic                  mul_en_in_q, mul_en_in_d;
  logic [7:0]            mul_a_q, mul_a_d;
  logic [7:0]            mul_b_q, mul_b_d;
  logic [NS-1:0]         tag_v_q, tag_v_d;
  logic [NS-1:0][IW-1:0] tag_id_q, tag_id_d;
  logic [N-1:0]          rsp_valid_q, rsp_valid_d;
  logic [N-1:0][15:0]    rsp_data_q, rsp_data_d;
  logic                  err_q, err_d;

  logic [N-1:0]  elig_s;
  logic [N-1:0]  grant_s;
  logic [IW-1:0] gidx_s;
  logic [IW-1:0] cand_s;
  logic          take_s;
  logic          found_s;
  logic [7:0]    sel_a_s;
  logic [7:0]    sel_b_s;
  logic [N-1:0]  cap_s;

  // Round-robin grant search, starting one past the last granted channel.
  always_comb begin
    elig_s  = req_valid & ~busy_q & {N{~rst}};
    grant_s = '0;
    gidx_s  = ptr_q;
    cand_s  = ptr_q;
    take_s  = 1'b0;
    found_s = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand_s          = IW'((int'(ptr_q) + k) % N);
      take_s          = ~found_s & elig_s[cand_s];
      grant_s[cand_s] = grant_s[cand_s] | take_s;
      gidx_s          = take_s ? cand_s : gidx_s;
      found_s         = found_s | take_s;
    end
  end

  // Issue path, tag shift register, response capture and sticky error.
  always_comb begin
    sel_a_s = 8'h00;
    sel_b_s = 8'h00;
    for (int i = 0; i < N; i++) begin
      sel_a_s = sel_a_s | (req_a[8*i +: 8] & {8{grant_s[i]}});
      sel_b_s = sel_b_s | (req_b[8*i +: 8] & {8{grant_s[i]}});
    end

    busy_d      = (busy_q | grant_s) & ~(rsp_valid_q & rsp_ready);
    ptr_d       = found_s ? gidx_s : ptr_q;
    mul_en_in_d = found_s;
    mul_a_d     = found_s ? sel_a_s : mul_a_q;
    mul_b_d     = found_s ? sel_b_s : mul_b_q;

    tag_v_d     = {tag_v_q[NS-2:0], found_s};
    tag_id_d    = tag_id_q;
    tag_id_d[0] = found_s ? gidx_s : {IW{1'b0}};
    for (int s = 1; s < NS; s++) begin
      tag_id_d[s] = tag_id_q[s-1];
    end

    // A missing or unexpected result strobe is an error; the tagged slot is filled regardless.
    cap_s       = {{(N-1){1'b0}}, tag_v_q[NS-1]} << tag_id_q[NS-1];
    rsp_valid_d = (rsp_valid_q & ~rsp_ready) | cap_s;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < N; i++) begin
      rsp_data_d[i] = cap_s[i] ? mul_out : rsp_data_q[i];
    end
    err_d = err_q | (tag_v_q[NS-1] ^ mul_en_out);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      ptr_q       <= PTR_RST;
      mul_en_in_q <= 1'b0;
      mul_a_q     <= 8'h00;
      mul_b_q     <= 8'h00;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      mul_en_in_q <= mul_en_in_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mul_en_in = mul_en_in_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mul_rr_sched.sv
// Directed bench for mul_rr_sched with a 3-cycle multiplier model that can drop or inject strobes.
module tb_mul_rr_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a, req_b;
  logic [63:0] rsp_data;
  logic        mul_en_in, mul_en_out, err;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_out;
  logic        inject, suppress;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         ch;
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] p;
  } vec_t;
  vec_t vecs [8];
  logic [3:0] rr_exp [14];

  always #5 clk = ~clk;

  mul_rr_sched #(.N(4), .LAT(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mul_en_in(mul_en_in), .mul_a(mul_a), .mul_b(mul_b),
    .mul_en_out(mul_en_out), .mul_out(mul_out), .err(err)
  );

  // Multiplier model: strobe and product appear 3 cycles after mul_en_in.
  logic [2:0]       mv_q;
  logic [2:0][15:0] mp_q;
  logic [15:0]      prod_s;
  assign prod_s = 16'(mul_a) * 16'(mul_b);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mv_q <= '0;
      mp_q <= '0;
    end else begin
      mv_q <= {mv_q[1:0], mul_en_in};
      mp_q <= {mp_q[1:0], prod_s};
    end
  end
  assign mul_en_out = (mv_q[2] & ~suppress) | inject;
  assign mul_out    = mp_q[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int ch, input logic [7:0] a, input logic [7:0] b);
    req_a[8*ch +: 8] = a;
    req_b[8*ch +: 8] = b;
  endtask

  initial begin
    vecs[0] = '{2, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{0, 8'h00, 8'h5A, 16'h0000};
    vecs[2] = '{1, 8'h80, 8'h02, 16'h0100};
    vecs[3] = '{3, 8'h0F, 8'h11, 16'h00FF};
    vecs[4] = '{2, 8'h12, 8'h34, 16'h03A8};
    vecs[5] = '{0, 8'hFF, 8'h01, 16'h00FF};
    vecs[6] = '{3, 8'hC8, 8'hC8, 16'h9C40};
    vecs[7] = '{1, 8'h01, 8'h01, 16'h0001};
    rr_exp = '{4'h1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h8};

    rst = 1'b1; req_valid = 4'hF; req_a = '0; req_b = '0; rsp_ready = 4'hF;
    inject = 1'b0; suppress = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 64'h0);
    chk("rst_rsp_valid", rsp_valid, 64'h0);
    chk("rst_rsp_data", rsp_data, 64'h0);
    chk("rst_mul", {mul_en_in, mul_a, mul_b}, 64'h0);
    chk("rst_err", err, 64'h0);
    req_valid = 4'h0;
    cyc();
    rst = 1'b0;

    // Single-request vectors: grant, issue, latency and product.
    for (int v = 0; v < 8; v++) begin
      cyc();
      req_valid = 4'(1 << vecs[v].ch);
      set_ops(vecs[v].ch, vecs[v].a, vecs[v].b);
      smp(); chk("vec_grant", req_ready, 64'(1 << vecs[v].ch));
      cyc();
      req_valid = 4'h0;
      smp(); chk("vec_en_in", mul_en_in, 64'h1);
      chk("vec_ops", {mul_a, mul_b}, {vecs[v].a, vecs[v].b});
      for (int k = 2; k <= 4; k++) begin
        cyc(); smp(); chk("vec_rsp_early", rsp_valid, 64'h0);
      end
      cyc(); smp();
      chk("vec_rsp_valid", rsp_valid, 64'(1 << vecs[v].ch));
      chk("vec_rsp_data", rsp_data[16*vecs[v].ch +: 16], vecs[v].p);
      chk("vec_err", err, 64'h0);
    end

    // All four channels request from reset: back-to-back grants and returns.
    req_valid = 4'hF; req_a = {8'd4, 8'd3, 8'd2, 8'd1}; req_b = {4{8'd3}}; rsp_ready = 4'hF;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      smp(); chk("all_grant", req_ready, 64'(1 << k));
    end
    cyc();
    req_valid = 4'h0;
    for (int k = 4; k <= 8; k++) begin
      if (k > 4) cyc();
      smp();
      if (k == 4) chk("all_rsp_none", rsp_valid, 64'h0);
      else begin
        chk("all_rsp_valid", rsp_valid, 64'(1 << (k - 5)));
        chk("all_rsp_data", rsp_data[16*(k-5) +: 16], 64'(3 * (k - 4)));
      end
    end

    // ch1 response stalled: data held, no regrant until consumed.
    req_valid = 4'b0111; req_a = {8'd0, 8'd3, 8'd5, 8'd2}; req_b = {8'd0, 8'd3, 8'd7, 8'd2};
    rsp_ready = 4'b1101;
    do_reset();
    begin
      int others;
      others = 0;
      for (int c = 1; c <= 15; c++) begin
        cyc(); smp();
        chk("stall_ch1_ready", req_ready[1], 64'(c == 1));
        if (c >= 6) begin
          chk("stall_rsp_valid", rsp_valid[1], 64'h1);
          chk("stall_rsp_data", rsp_data[31:16], 64'h0023);
          others = others + int'(req_ready[0] | req_ready[2]);
        end
      end
      chk("stall_others_granted", 64'(others >= 2), 64'h1);
    end
    cyc();
    rsp_ready = 4'hF; req_valid = 4'b0010;
    smp(); chk("stall_consume_no_grant", req_ready, 64'h0);
    cyc(); smp();
    chk("stall_regrant", req_ready, 64'h2);
    chk("stall_rsp_cleared", rsp_valid[1], 64'h0);
    cyc();
    req_valid = 4'h0;
    repeat (8) cyc();
    smp(); chk("stall_err", err, 64'h0);

    // ch0 and ch3 continuous: alternate grants with wrap 3 -> 0.
    req_valid = 4'b1001; rsp_ready = 4'hF;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      if (c > 0) cyc();
      smp(); chk("rr_cont", req_ready, 64'(rr_exp[c]));
    end
    cyc();
    req_valid = 4'h0;
    repeat (8) cyc();

    // Contention with ptr on ch1: ch3 must win over ch0.
    req_valid = 4'b1011; rsp_ready = 4'h0;
    do_reset();
    smp(); chk("rr_c0", req_ready, 64'h1);
    cyc(); smp(); chk("rr_c1", req_ready, 64'h2);
    cyc(); smp(); chk("rr_c2", req_ready, 64'h8);
    repeat (5) cyc();
    cyc();
    rsp_ready = 4'b0010;
    smp(); chk("rr_c8", req_ready, 64'h0);
    cyc();
    rsp_ready = 4'hF;
    smp(); chk("rr_c9", req_ready, 64'h2);
    cyc(); smp(); chk("rr_c10", req_ready, 64'h8);
    cyc(); smp(); chk("rr_c11", req_ready, 64'h1);
    cyc();
    req_valid = 4'h0;
    repeat (8) cyc();

    // Unexpected result strobe.
    rsp_ready = 4'hF;
    do_reset();
    smp(); chk("inj_err_pre", err, 64'h0);
    cyc();
    inject = 1'b1;
    cyc();
    inject = 1'b0;
    smp(); chk("inj_err", err, 64'h1);
    chk("inj_rsp", rsp_valid, 64'h0);
    repeat (5) cyc();
    smp(); chk("inj_err_sticky", err, 64'h1);
    chk("inj_rsp_late", rsp_valid, 64'h0);

    // Missing result strobe: response still delivered, err raised.
    do_reset();
    smp(); chk("sup_err_pre", err, 64'h0);
    cyc();
    req_valid = 4'b0010; set_ops(1, 8'd9, 8'd9); suppress = 1'b1;
    cyc();
    req_valid = 4'h0;
    repeat (3) cyc();
    smp(); chk("sup_err_early", err, 64'h0);
    cyc(); smp();
    chk("sup_rsp_valid", rsp_valid, 64'h2);
    chk("sup_rsp_data", rsp_data[31:16], 64'h0051);
    chk("sup_err", err, 64'h1);
    suppress = 1'b0;

    // Reset with operations in flight.
    cyc();
    req_valid = 4'b0011; set_ops(0, 8'd7, 8'd7); set_ops(1, 8'd2, 8'd2);
    smp(); chk("mid_g0", req_ready, 64'h1);
    cyc(); smp(); chk("mid_g1", req_ready, 64'h2);
    cyc();
    req_valid = 4'hF;
    cyc();
    rst = 1'b1;
    #1;
    chk("mid_req_ready", req_ready, 64'h0);
    chk("mid_rsp_valid", rsp_valid, 64'h0);
    chk("mid_rsp_data", rsp_data, 64'h0);
    chk("mid_mul", {mul_en_in, mul_a, mul_b}, 64'h0);
    chk("mid_err", err, 64'h0);
    cyc();
    cyc();
    rst = 1'b0;
    smp(); chk("mid_first_grant", req_ready, 64'h1);
    cyc();
    req_valid = 4'h0;
    repeat (8) cyc();
    smp(); chk("mid_err_after", err, 64'h0);
    chk("mid_rsp_after", rsp_valid, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
